// File: rtl/spi_pixel_streamer.sv
// spi_pixel_streamer
//   Captures PIX_W-bit pixels from an image sensor parallel bus (gated by
//   vsync/hsync) into a 2^ADDR_W-word FIFO and streams them MSB-first to an
//   external SPI master (mode 0, this block is the slave). Everything runs on
//   daq_clk; all sensor and SPI pins are oversampled through synchronisers.
//
//   Optional feature macro: FRAME_HEADER_EN
//     defined   - every frame start pushes HDR_WORD then frame_cnt[PIX_W-1:0]
//     undefined - the stream carries pixels only
//
// Ports
//   daq_clk          in   system clock (>= 2x pclk, >= 8x sck)
//   sys_rst_n        in   asynchronous active-low reset
//   pix_data         in   sensor pixel bus, valid at pclk rising edge
//   pclk             in   sensor pixel clock
//   vsync / hsync    in   frame / line valid, active-high
//   cs_n / sck       in   SPI chip select (active-low) and clock
//   miso             out  serial data, shift register MSB (0 while idle)
//   handshake_start  out  registered (fifo_level >= WM)
//   fifo_level       out  FIFO occupancy, ADDR_W+1 bits
//   overflow         out  sticky per frame: a push was dropped
//   frame_cnt        out  completed frame count, wraps
//
// Capture FSM
//   state      | meaning
//   CAP_IDLE   | between frames, waiting for vsync rise
//   CAP_FRAME  | frame active, pixels with hsync high are pushed
//
// SPI FSM
//   state      | meaning
//   SPI_IDLE   | cs_n high, miso held at 0
//   SPI_SHIFT  | shifting the current word out on sck falling edges
//   SPI_LOAD   | one-cycle reload of the next word after a full word

module spi_pixel_streamer #(
  parameter int unsigned      PIX_W     = 8,
  parameter int unsigned      ADDR_W    = 8,
  parameter int unsigned      WM        = 128,
  parameter logic [PIX_W-1:0] FILL_WORD = '1,
  parameter logic [15:0]      HDR_WORD  = 16'hA5A5
) (
  input  logic              daq_clk,
  input  logic              sys_rst_n,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              hsync,
  input  logic              cs_n,
  input  logic              sck,
  output logic              miso,
  output logic              handshake_start,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned      DEPTH    = 1 << ADDR_W;
  localparam int unsigned      CNT_W    = $clog2(PIX_W);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  WM_L     = (ADDR_W+1)'(WM);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PIX_W - 1);

  typedef enum logic {CAP_IDLE, CAP_FRAME} cap_state_t;
  typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_LOAD} spi_state_t;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0] pclk_sr_q, pclk_sr_d;
  logic [2:0] vsync_sr_q, vsync_sr_d;
  logic [2:0] sck_sr_q, sck_sr_d;
  logic [2:0] cs_sr_q, cs_sr_d;
  logic [1:0] hsync_sr_q, hsync_sr_d;
  logic [1:0][PIX_W-1:0] pix_dly_q, pix_dly_d;

  cap_state_t cap_state_q, cap_state_d;
  spi_state_t spi_state_q, spi_state_d;
  logic [PIX_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              hs_q, hs_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [PIX_W-1:0]  mem_q [DEPTH];

`ifdef FRAME_HEADER_EN
  logic hdr_pend_q, hdr_pend_d;
`else
  logic hdr_unused;
  assign hdr_unused = ^HDR_WORD;
`endif

  logic             pclk_rise, vsync_rise, vsync_fall, sck_fall, cs_fall, cs_rise;
  logic             hsync_s;
  logic             push, push_ok, pop, do_load;
  logic [PIX_W-1:0] push_data;

  assign pclk_rise  =  pclk_sr_q[1]  & ~pclk_sr_q[2];
  assign vsync_rise =  vsync_sr_q[1] & ~vsync_sr_q[2];
  assign vsync_fall = ~vsync_sr_q[1] &  vsync_sr_q[2];
  assign sck_fall   = ~sck_sr_q[1]   &  sck_sr_q[2];
  assign cs_fall    = ~cs_sr_q[1]    &  cs_sr_q[2];
  assign cs_rise    =  cs_sr_q[1]    & ~cs_sr_q[2];
  assign hsync_s    =  hsync_sr_q[1];

  always_comb begin
    pclk_sr_d  = {pclk_sr_q[1:0], pclk};
    vsync_sr_d = {vsync_sr_q[1:0], vsync};
    sck_sr_d   = {sck_sr_q[1:0], sck};
    cs_sr_d    = {cs_sr_q[1:0], cs_n};
    hsync_sr_d = {hsync_sr_q[0], hsync};
    pix_dly_d  = {pix_dly_q[0], pix_data};
  end

  // Capture FSM and FIFO bookkeeping
  always_comb begin
    cap_state_d = cap_state_q;
    ovf_d       = ovf_q;
    fcnt_d      = fcnt_q;
    push        = 1'b0;
    push_data   = '0;
`ifdef FRAME_HEADER_EN
    hdr_pend_d  = 1'b0;
`endif
    unique case (cap_state_q)
      CAP_IDLE: begin
        if (vsync_rise) begin
          cap_state_d = CAP_FRAME;
          ovf_d       = 1'b0;
`ifdef FRAME_HEADER_EN
          push        = 1'b1;
          push_data   = HDR_WORD[PIX_W-1:0];
          hdr_pend_d  = 1'b1;
`endif
        end
      end
      CAP_FRAME: begin
`ifdef FRAME_HEADER_EN
        // second header word goes out the cycle after the marker
        if (hdr_pend_q) begin
          push      = 1'b1;
          push_data = fcnt_q[PIX_W-1:0];
        end else
`endif
        if (pclk_rise && hsync_s) begin
          push      = 1'b1;
          push_data = pix_dly_q[1];
        end
        if (vsync_fall) begin
          cap_state_d = CAP_IDLE;
          fcnt_d      = fcnt_q + 16'd1;
        end
      end
      default: cap_state_d = CAP_IDLE;
    endcase

    // full is judged on the start-of-cycle level, a same-cycle pop does not help
    push_ok = push && (level_q != DEPTH_L);
    if (push && !push_ok) ovf_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
    hs_d = (level_d >= WM_L);
  end

  // SPI FSM
  always_comb begin
    spi_state_d = spi_state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    do_load     = 1'b0;
    pop         = 1'b0;
    unique case (spi_state_q)
      SPI_IDLE: begin
        if (cs_fall) begin
          do_load     = 1'b1;
          spi_state_d = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (sck_fall) begin
          sr_d      = {sr_q[PIX_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == BIT_LAST) spi_state_d = SPI_LOAD;
        end
      end
      SPI_LOAD: begin
        do_load     = 1'b1;
        spi_state_d = SPI_SHIFT;
      end
      default: spi_state_d = SPI_IDLE;
    endcase

    // chip select release wins; any partly sent word is simply dropped
    if (cs_rise) begin
      spi_state_d = SPI_IDLE;
      do_load     = 1'b0;
    end

    if (do_load) begin
      bit_cnt_d = '0;
      if (level_q != '0) begin
        sr_d = mem_q[rd_ptr_q];
        pop  = 1'b1;
      end else begin
        sr_d = FILL_WORD;
      end
    end
  end

  always_ff @(posedge daq_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pclk_sr_q   <= '0;
      vsync_sr_q  <= '0;
      sck_sr_q    <= '0;
      cs_sr_q     <= '1;
      hsync_sr_q  <= '0;
      pix_dly_q   <= '0;
      cap_state_q <= CAP_IDLE;
      spi_state_q <= SPI_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      hs_q        <= 1'b0;
      ovf_q       <= 1'b0;
      fcnt_q      <= '0;
`ifdef FRAME_HEADER_EN
      hdr_pend_q  <= 1'b0;
`endif
    end else begin
      pclk_sr_q   <= pclk_sr_d;
      vsync_sr_q  <= vsync_sr_d;
      sck_sr_q    <= sck_sr_d;
      cs_sr_q     <= cs_sr_d;
      hsync_sr_q  <= hsync_sr_d;
      pix_dly_q   <= pix_dly_d;
      cap_state_q <= cap_state_d;
      spi_state_q <= spi_state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      hs_q        <= hs_d;
      ovf_q       <= ovf_d;
      fcnt_q      <= fcnt_d;
`ifdef FRAME_HEADER_EN
      hdr_pend_q  <= hdr_pend_d;
`endif
    end
  end

  always_ff @(posedge daq_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign miso            = (spi_state_q != SPI_IDLE) && sr_q[PIX_W-1];
  assign handshake_start = hs_q;
  assign fifo_level      = level_q;
  assign overflow        = ovf_q;
  assign frame_cnt       = fcnt_q;

endmodule

// File: tb/tb_spi_pixel_streamer.sv
// Testbench for spi_pixel_streamer (PIX_W=8, ADDR_W=4, WM=4).
// A queue-based model of the pixel stream predicts FIFO contents, level,
// overflow, frame count and every word the SPI master receives.

module tb_spi_pixel_streamer;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 4;
  localparam int WM     = 4;
  localparam int DEPTH  = 16;

  logic        daq_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  pix_data;
  logic        pclk, vsync, hsync, cs_n, sck;
  logic        miso, handshake_start, overflow;
  logic [4:0]  fifo_level;
  logic [15:0] frame_cnt;

  always #5 daq_clk = ~daq_clk;

  spi_pixel_streamer #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .WM(WM)) dut (
    .daq_clk(daq_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data), .pclk(pclk),
    .vsync(vsync), .hsync(hsync), .cs_n(cs_n), .sck(sck), .miso(miso),
    .handshake_start(handshake_start), .fifo_level(fifo_level),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int n_push;
    int n_pop;
    int exp_level;
    bit exp_hs;
    bit exp_ovf;
  } vec_t;

  vec_t tbl [8];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0]  mq [$];
  bit          m_ovf;
  logic [15:0] m_fcnt;
  bit          m_in_frame;
  logic [7:0]  m_cur;
  logic [7:0]  pix_ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge daq_clk);
    #1;
  endtask

  function automatic void m_push(input logic [7:0] d);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(d);
  endfunction

  function automatic logic [7:0] m_load();
    if (mq.size() > 0) return mq.pop_front();
    return 8'hFF;
  endfunction

  function automatic void m_frame_open();
    m_ovf = 1'b0;
`ifdef FRAME_HEADER_EN
    m_push(8'hA5);
    m_push(m_fcnt[7:0]);
`endif
    m_in_frame = 1'b1;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".level"},    32'(fifo_level),      32'(mq.size()));
    check({tag, ".hs"},       32'(handshake_start), 32'(mq.size() >= WM));
    check({tag, ".overflow"}, 32'(overflow),        32'(m_ovf));
    check({tag, ".frame_cnt"},32'(frame_cnt),       32'(m_fcnt));
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    cyc(6);
    m_frame_open();
  endtask

  task automatic frame_end();
    vsync = 1'b0;
    cyc(6);
    m_fcnt     = m_fcnt + 16'd1;
    m_in_frame = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] d, input bit hs);
    pix_data = d;
    hsync    = hs;
    cyc(1);
    pclk = 1'b1;
    cyc(3);
    pclk = 1'b0;
    cyc(3);
    if (m_in_frame && hs) m_push(d);
  endtask

  // cs_n low, nwords full words, then abort_bits extra bits, then cs_n high
  task automatic spi_read(input int nwords, input int abort_bits);
    logic [7:0] w;
    logic [7:0] part;
    w = '0;
    cs_n = 1'b0;
    cyc(6);
    m_cur = m_load();
    for (int k = 0; k < nwords; k++) begin
      for (int b = 7; b >= 0; b--) begin
        cyc(5);
        w[b] = miso;
        sck = 1'b1;
        cyc(5);
        sck = 1'b0;
      end
      check("spi_word", 32'(w), 32'(m_cur));
      m_cur = m_load();
    end
    if (abort_bits > 0) begin
      part = '0;
      for (int b = 0; b < abort_bits; b++) begin
        cyc(5);
        part = {part[6:0], miso};
        sck = 1'b1;
        cyc(5);
        sck = 1'b0;
      end
      check("spi_partial", 32'(part), 32'(m_cur >> (8 - abort_bits)));
    end
    cyc(5);
    cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic drain();
    while (mq.size() > 0) spi_read(0, 0);
  endtask

  initial begin
    tbl[0] = '{3,  0, 3,  1'b0, 1'b0};
    tbl[1] = '{1,  0, 4,  1'b1, 1'b0};
    tbl[2] = '{0,  1, 3,  1'b0, 1'b0};
    tbl[3] = '{13, 0, 16, 1'b1, 1'b0};
    tbl[4] = '{4,  0, 16, 1'b1, 1'b1};
    tbl[5] = '{0,  2, 14, 1'b1, 1'b1};
    tbl[6] = '{2,  0, 16, 1'b1, 1'b1};
    tbl[7] = '{1,  0, 16, 1'b1, 1'b1};

    m_ovf = 1'b0; m_fcnt = '0; m_in_frame = 1'b0; m_cur = '0; pix_ctr = 8'h40;
    pix_data = '0; pclk = 1'b0; vsync = 1'b0; hsync = 1'b0; cs_n = 1'b1; sck = 1'b0;
    sys_rst_n = 1'b0;
    cyc(3);
    check("rst.miso",      32'(miso), 0);
    check("rst.hs",        32'(handshake_start), 0);
    check("rst.level",     32'(fifo_level), 0);
    check("rst.overflow",  32'(overflow), 0);
    check("rst.frame_cnt", 32'(frame_cnt), 0);
    sys_rst_n = 1'b1;
    cyc(4);
    check_status("post_rst");

    // frame 1: two lines of 6 ramp pixels, blanking pixels in between
    frame_start();
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 6; p++) pixel(8'(l * 6 + p), 1'b1);
      pixel(8'hEE, 1'b0);
      pixel(8'hEE, 1'b0);
    end
    frame_end();
    check("frame1_cnt", 32'(frame_cnt), 1);
    check_status("frame1");
    spi_read(mq.size() + 2, 0);
    check_status("frame1_read");

    // empty FIFO delivers fill words and stays empty
    spi_read(2, 0);
    check_status("fill");
    check("miso_idle", 32'(miso), 0);

    // level / watermark / overflow table
    frame_start();
    drain();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < tbl[i].n_push; p++) begin
        pixel(pix_ctr, 1'b1);
        pix_ctr = pix_ctr + 8'd1;
      end
      for (int p = 0; p < tbl[i].n_pop; p++) spi_read(0, 0);
      check($sformatf("tbl%0d.level", i), 32'(fifo_level), 32'(tbl[i].exp_level));
      check($sformatf("tbl%0d.hs", i),    32'(handshake_start), 32'(tbl[i].exp_hs));
      check($sformatf("tbl%0d.ovf", i),   32'(overflow), 32'(tbl[i].exp_ovf));
    end
    spi_read(16, 0);
    check_status("ovf_readback");
    frame_end();
    frame_start();
    check("ovf_clear", 32'(overflow), 0);
    check_status("ovf_clear");

    // pixel write lands exactly 3 cycles after the pclk rise
    drain();
    pixel(8'h11, 1'b1);
    pixel(8'h22, 1'b1);
    pixel(8'h33, 1'b1);
    check("lat.hs_before", 32'(handshake_start), 0);
    pix_data = 8'h44;
    hsync    = 1'b1;
    cyc(1);
    pclk = 1'b1;
    cyc(2);
    check("lat.level_2cyc", 32'(fifo_level), 3);
    check("lat.hs_2cyc",    32'(handshake_start), 0);
    cyc(1);
    check("lat.level_3cyc", 32'(fifo_level), 4);
    check("lat.hs_3cyc",    32'(handshake_start), 1);
    pclk = 1'b0;
    cyc(3);
    m_push(8'h44);
    spi_read(0, 0);
    check_status("lat.pop");

    // first MSB shows up within 4 cycles of the cs_n fall
    drain();
    pixel(8'h81, 1'b1);
    check("miso_idle2", 32'(miso), 0);
    cs_n = 1'b0;
    cyc(2);
    check("miso_pre", 32'(miso), 0);
    cyc(2);
    check("miso_first", 32'(miso), 1);
    m_cur = m_load();
    cs_n = 1'b1;
    cyc(6);

    // abort mid-word: 0x5A partly sent, then the following entries
    drain();
    pixel(8'h5A, 1'b1);
    pixel(8'h3C, 1'b1);
    pixel(8'h99, 1'b1);
    spi_read(0, 3);
    spi_read(2, 0);
    check_status("abort");
    frame_end();

    // zero-length frame
    vsync = 1'b1;
    cyc(3);
    vsync = 1'b0;
    cyc(8);
    m_frame_open();
    m_fcnt = m_fcnt + 16'd1;
    m_in_frame = 1'b0;
    check_status("zero_frame");
    drain();

    // randomized frames and reads
    for (int it = 0; it < 20; it++) begin
      int np, nw, ab;
      frame_start();
      np = $urandom_range(0, 10);
      for (int p = 0; p < np; p++) pixel(8'($urandom), ($urandom_range(0, 3) != 0));
      frame_end();
      check_status("rand_cap");
      nw = $urandom_range(0, mq.size() + 1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      spi_read(nw, ab);
      check_status("rand_rd");
    end

    // reset in the middle of a word
    frame_start();
    pixel(8'hC3, 1'b1);
    pixel(8'h3C, 1'b1);
    frame_end();
    cs_n = 1'b0;
    cyc(6);
    for (int b = 0; b < 3; b++) begin
      cyc(5); sck = 1'b1; cyc(5); sck = 1'b0;
    end
    sys_rst_n = 1'b0;
    #1;
    check("rst2.miso",      32'(miso), 0);
    check("rst2.level",     32'(fifo_level), 0);
    check("rst2.hs",        32'(handshake_start), 0);
    check("rst2.overflow",  32'(overflow), 0);
    check("rst2.frame_cnt", 32'(frame_cnt), 0);
    cs_n = 1'b1;
    cyc(3);
    sys_rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_fcnt = '0; m_in_frame = 1'b0;
    cyc(4);
    check_status("rst2.after");
    spi_read(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
